// File: rtl/axis_bist_checker.sv
// Receive-side BIST checker for 64-bit CVITA packets: validates header SID, length and
// sequence number, compares payload against a constant or ramp pattern, and reports status.
module axis_bist_checker #(
  parameter int SID_CHECK = 1,
  parameter int CNT_W     = 32
) (
  input  logic             bus_clk,
  input  logic             bus_rst_n,
  input  logic [63:0]      i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  input  logic             ctrl_en,
  input  logic             ctrl_cont,
  input  logic             cfg_ramp,
  input  logic [12:0]      cfg_pkt_bytes,
  input  logic [17:0]      cfg_num_pkts,
  input  logic [31:0]      cfg_pattern,
  input  logic [31:0]      cfg_sid,
  output logic             running,
  output logic             done,
  output logic [1:0]       error,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;
  state_t state, state_nxt;

  logic        en_d, cont_q, ramp_q;
  logic [12:0] pkt_bytes_q;
  logic [17:0] num_pkts_q;
  logic [31:0] pattern_q, sid_q;
  logic [11:0] seq_q;
  logic [63:0] ramp_val;
  logic [9:0]  word_idx;
  logic        discard, cyc_on;

  logic        beat, rise, start, eop, cmp, set_e0, set_e1;
  logic [9:0]  last_idx;
  logic [63:0] exp_word;
  logic        hdr_bad, data_bad;
  logic [CNT_W:0] pkt_inc;
  logic [1:0]  err_after;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign i_tready = (state == S_HDR) || (state == S_DATA);
  assign running  = i_tready;
  assign beat     = i_tvalid & i_tready;
  assign rise     = ctrl_en & ~en_d;
  assign last_idx = pkt_bytes_q[12:3] - 10'd1;
  assign exp_word = ramp_q ? ramp_val : {pattern_q, pattern_q};
  assign hdr_bad  = (i_tdata[47:32] != {3'b000, pkt_bytes_q}) || (i_tdata[59:48] != seq_q) ||
                    ((SID_CHECK != 0) && (i_tdata[31:0] != sid_q)) || i_tlast;
  assign data_bad = (i_tdata != exp_word);
  assign pkt_inc  = {1'b0, pkt_cnt} + (CNT_W+1)'(1);

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    eop       = 1'b0;
    cmp       = 1'b0;
    set_e0    = 1'b0;
    set_e1    = 1'b0;
    err_after = error;
    case (state)
      S_IDLE: begin
        if (rise) begin
          start     = 1'b1;
          state_nxt = ((cfg_num_pkts == '0) && !ctrl_cont) ? S_DONE : S_HDR;
        end
      end
      S_HDR: begin
        if (cont_q && !ctrl_en) begin
          state_nxt = S_DONE;
        end else if (beat) begin
          set_e1 = hdr_bad;
          if (i_tlast) eop = 1'b1;
          else         state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          if (!discard) begin
            cmp    = 1'b1;
            set_e0 = data_bad;
          end
          if (i_tlast) begin
            eop       = 1'b1;
            state_nxt = S_HDR;
            if (!discard && (word_idx != last_idx)) set_e1 = 1'b1;
          end else if (!discard && (word_idx == last_idx)) begin
            set_e1 = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!ctrl_en) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Stop decision sees errors raised by the terminating beat itself.
    err_after = error | {set_e1, set_e0};
    if (eop && ((!cont_q && (pkt_inc == (CNT_W+1)'(num_pkts_q))) ||
                (cont_q && (!ctrl_en || (err_after != 2'b00)))))
      state_nxt = S_DONE;
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      en_d        <= 1'b0;
      cont_q      <= 1'b0;
      ramp_q      <= 1'b0;
      pkt_bytes_q <= '0;
      num_pkts_q  <= '0;
      pattern_q   <= '0;
      sid_q       <= '0;
      seq_q       <= '0;
      ramp_val    <= '0;
      word_idx    <= '0;
      discard     <= 1'b0;
      cyc_on      <= 1'b0;
      done        <= 1'b0;
      error       <= '0;
      pkt_cnt     <= '0;
      xfer_cnt    <= '0;
      cyc_cnt     <= '0;
    end else begin
      en_d <= ctrl_en;
      if (start) begin
        cont_q      <= ctrl_cont;
        ramp_q      <= cfg_ramp;
        pkt_bytes_q <= cfg_pkt_bytes;
        num_pkts_q  <= cfg_num_pkts;
        pattern_q   <= cfg_pattern;
        sid_q       <= cfg_sid;
        seq_q       <= '0;
        ramp_val    <= '0;
        word_idx    <= '0;
        discard     <= 1'b0;
        cyc_on      <= 1'b0;
        done        <= (state_nxt == S_DONE);
        error       <= '0;
        pkt_cnt     <= '0;
        xfer_cnt    <= '0;
        cyc_cnt     <= '0;
      end else begin
        error <= err_after;
        if (beat) xfer_cnt <= sat_inc(xfer_cnt);
        if (running && (cyc_on || ((state == S_HDR) && beat))) cyc_cnt <= sat_inc(cyc_cnt);
        if ((state == S_HDR) && beat) begin
          cyc_on   <= 1'b1;
          word_idx <= 10'd1;
          discard  <= 1'b0;
        end
        if (cmp) begin
          ramp_val <= ramp_val + 64'd1;
          if (!i_tlast) word_idx <= word_idx + 10'd1;
          if (!i_tlast && (word_idx == last_idx)) discard <= 1'b1;
        end
        if (eop) begin
          pkt_cnt <= sat_inc(pkt_cnt);
          seq_q   <= seq_q + 12'd1;
        end
        if ((state_nxt == S_DONE) && (state != S_DONE)) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_bist_checker.sv
// Directed self-checking bench for axis_bist_checker (100 MHz bus_clk).
module tb_axis_bist_checker;

  localparam int CNT_W = 32;

  logic             bus_clk = 1'b0;
  logic             bus_rst_n;
  logic [63:0]      i_tdata;
  logic             i_tlast;
  logic             i_tvalid;
  logic             i_tready;
  logic             ctrl_en;
  logic             ctrl_cont;
  logic             cfg_ramp;
  logic [12:0]      cfg_pkt_bytes;
  logic [17:0]      cfg_num_pkts;
  logic [31:0]      cfg_pattern;
  logic [31:0]      cfg_sid;
  logic             running;
  logic             done;
  logic [1:0]       error;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] xfer_cnt;
  logic [CNT_W-1:0] cyc_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [63:0] tb_ramp;

  axis_bist_checker #(.SID_CHECK(1), .CNT_W(CNT_W)) dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .ctrl_en(ctrl_en), .ctrl_cont(ctrl_cont), .cfg_ramp(cfg_ramp),
    .cfg_pkt_bytes(cfg_pkt_bytes), .cfg_num_pkts(cfg_num_pkts),
    .cfg_pattern(cfg_pattern), .cfg_sid(cfg_sid),
    .running(running), .done(done), .error(error),
    .pkt_cnt(pkt_cnt), .xfer_cnt(xfer_cnt), .cyc_cnt(cyc_cnt)
  );

  always #5 bus_clk = ~bus_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic put(input logic [63:0] d, input logic last);
    int unsigned t = 0;
    i_tdata  = d;
    i_tlast  = last;
    i_tvalid = 1'b1;
    while (!i_tready && t < 200) begin
      @(negedge bus_clk);
      t++;
    end
    if (t >= 200) check("tready_wait", 64'(i_tready), 64'd1);
    @(negedge bus_clk);
  endtask

  task automatic send_pkt(input logic [11:0] seq, input logic [15:0] lenf, input int nbeats,
                          input int flip_idx, input int drop_beat);
    logic [63:0] w;
    put({4'h0, seq, lenf, cfg_sid}, nbeats == 1);
    for (int i = 1; i < nbeats; i++) begin
      if (i == drop_beat) ctrl_en = 1'b0;
      w = cfg_ramp ? tb_ramp : {cfg_pattern, cfg_pattern};
      if (cfg_ramp) tb_ramp = tb_ramp + 64'd1;
      if (i == flip_idx) w[63] = ~w[63];
      put(w, i == nbeats - 1);
    end
  endtask

  task automatic start_run();
    ctrl_en = 1'b0;
    repeat (2) @(negedge bus_clk);
    ctrl_en = 1'b1;
    tb_ramp = '0;
    @(negedge bus_clk);
  endtask

  task automatic stop_run();
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    ctrl_en  = 1'b0;
    repeat (3) @(negedge bus_clk);
  endtask

  initial begin
    int unsigned ratio;
    bus_rst_n     = 1'b0;
    i_tdata       = '0;
    i_tlast       = 1'b0;
    i_tvalid      = 1'b0;
    ctrl_en       = 1'b0;
    ctrl_cont     = 1'b0;
    cfg_ramp      = 1'b0;
    cfg_pkt_bytes = 13'd40;
    cfg_num_pkts  = 18'd10;
    cfg_pattern   = 32'h0123_4567;
    cfg_sid       = 32'hABCD_1234;
    tb_ramp       = '0;
    repeat (3) @(negedge bus_clk);
    check("rst_tready", 64'(i_tready), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_pkt", 64'(pkt_cnt), 64'd0);
    bus_rst_n = 1'b1;
    repeat (2) @(negedge bus_clk);

    // Constant pattern, 10 x 40-byte packets, clean stream
    start_run();
    check("t1_running", 64'(running), 64'd1);
    check("t1_tready", 64'(i_tready), 64'd1);
    for (int unsigned p = 0; p < 10; p++) send_pkt(12'(p), 16'd40, 5, -1, -1);
    i_tvalid = 1'b0;
    check("t1_done", 64'(done), 64'd1);
    check("t1_running_end", 64'(running), 64'd0);
    check("t1_error", 64'(error), 64'd0);
    check("t1_pkt", 64'(pkt_cnt), 64'd10);
    check("t1_xfer", 64'(xfer_cnt), 64'd50);
    check("t1_cyc", 64'(cyc_cnt), 64'd50);
    stop_run();
    check("t1_done_held", 64'(done), 64'd1);

    // Ramp pattern, 200 packets, bit 63 flipped in packet 3 payload word 1
    cfg_ramp     = 1'b1;
    cfg_num_pkts = 18'd200;
    start_run();
    check("t2_done_cleared", 64'(done), 64'd0);
    for (int unsigned p = 0; p < 200; p++) send_pkt(12'(p), 16'd40, 5, (p == 3) ? 1 : -1, -1);
    i_tvalid = 1'b0;
    check("t2_done", 64'(done), 64'd1);
    check("t2_error", 64'(error), 64'd1);
    check("t2_pkt", 64'(pkt_cnt), 64'd200);
    check("t2_xfer", 64'(xfer_cnt), 64'd1000);
    stop_run();

    // Bad length field in packet 0, early tlast in packet 1
    cfg_ramp     = 1'b0;
    cfg_num_pkts = 18'd10;
    start_run();
    send_pkt(12'd0, 16'd48, 5, -1, -1);
    check("t3_err_len", 64'(error), 64'd2);
    send_pkt(12'd1, 16'd40, 3, -1, -1);
    for (int unsigned p = 2; p < 10; p++) send_pkt(12'(p), 16'd40, 5, -1, -1);
    i_tvalid = 1'b0;
    check("t3_done", 64'(done), 64'd1);
    check("t3_error", 64'(error), 64'd2);
    check("t3_pkt", 64'(pkt_cnt), 64'd10);
    check("t3_xfer", 64'(xfer_cnt), 64'd48);
    stop_run();

    // Continuous, 256-byte packets, ctrl_en dropped mid-packet near 2 us
    ctrl_cont     = 1'b1;
    cfg_pkt_bytes = 13'd256;
    start_run();
    for (int unsigned p = 0; p < 7; p++) send_pkt(12'(p), 16'd256, 32, -1, (p == 6) ? 8 : -1);
    i_tvalid = 1'b0;
    check("t4_done", 64'(done), 64'd1);
    check("t4_running", 64'(running), 64'd0);
    check("t4_error", 64'(error), 64'd0);
    check("t4_pkt", 64'(pkt_cnt), 64'd7);
    check("t4_xfer", 64'(xfer_cnt), 64'd224);
    stop_run();

    // Continuous, payload error at 10 us stops the run after that packet
    start_run();
    for (int unsigned p = 0; p < 32; p++) send_pkt(12'(p), 16'd256, 32, (p == 31) ? 8 : -1, -1);
    i_tvalid = 1'b0;
    check("t5_done", 64'(done), 64'd1);
    check("t5_error", 64'(error), 64'd1);
    check("t5_pkt", 64'(pkt_cnt), 64'd32);
    check("t5_tready", 64'(i_tready), 64'd0);
    stop_run();

    // Reset mid-packet, then zero-packet run
    ctrl_cont     = 1'b0;
    cfg_pkt_bytes = 13'd40;
    cfg_num_pkts  = 18'd10;
    start_run();
    put({4'h0, 12'd0, 16'd48, cfg_sid}, 1'b0);
    put({cfg_pattern, cfg_pattern}, 1'b0);
    check("t6_pre_err", 64'(error), 64'd2);
    bus_rst_n = 1'b0;
    ctrl_en   = 1'b0;
    i_tvalid  = 1'b0;
    #1;
    check("t6_rst_running", 64'(running), 64'd0);
    check("t6_rst_tready", 64'(i_tready), 64'd0);
    check("t6_rst_error", 64'(error), 64'd0);
    check("t6_rst_xfer", 64'(xfer_cnt), 64'd0);
    @(negedge bus_clk);
    bus_rst_n    = 1'b1;
    cfg_num_pkts = 18'd0;
    repeat (2) @(negedge bus_clk);
    ctrl_en = 1'b1;
    check("t6_done_before_edge", 64'(done), 64'd0);
    @(negedge bus_clk);
    check("t6_done", 64'(done), 64'd1);
    check("t6_error", 64'(error), 64'd0);
    check("t6_running", 64'(running), 64'd0);
    stop_run();

    // Full-rate source: 10 x 800-byte packets
    cfg_pkt_bytes = 13'd800;
    cfg_num_pkts  = 18'd10;
    start_run();
    for (int unsigned p = 0; p < 10; p++) send_pkt(12'(p), 16'd800, 100, -1, -1);
    i_tvalid = 1'b0;
    ratio = (cyc_cnt == '0) ? 0 : int'((64'(xfer_cnt) * 64'd100) / 64'(cyc_cnt));
    check("t7_xfer", 64'(xfer_cnt), 64'd1000);
    check("t7_cyc", 64'(cyc_cnt), 64'd1000);
    check("t7_ratio", 64'(ratio), 64'd100);
    check("t7_error", 64'(error), 64'd0);
    stop_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
